// File: rtl/seg_display_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with a double-buffered
// frame and a two-requester round-robin write arbiter. Each digit slot ends
// with a blanking gap, and brightness gates the anodes with a 4-bit PWM.
module seg_display_ctrl #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned BLANK    = 500
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    input  logic [3:0]  brightness,
    output logic [3:0]  digit_code,
    output logic [3:0]  an,
    output logic        frame_start,
    output logic        last_writer
);

    localparam int unsigned   CW          = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_START = CW'(SCAN_DIV - BLANK);
    localparam logic [15:0]   DASH_FRAME  = 16'hAAAA;
    localparam logic [3:0]    DASH_CODE   = 4'hA;

    typedef enum logic {
        PH_SCAN,
        PH_BLANK
    } phase_e;

    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   active_q, active_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    logic [3:0]    pwm_cnt_q, pwm_cnt_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    digit_code_q, digit_code_d;
    logic          frame_start_q, frame_start_d;
    logic          last_writer_q, last_writer_d;

    logic          grant0;
    logic          grant1;
    logic          slot_wrap;
    logic          frame_swap;
    phase_e        phase;

    // Grant at most one requester per cycle; rr_ptr breaks ties. No grant while in reset.
    always_comb begin
        grant0 = reset_n & req0_valid & (~req1_valid | ~rr_ptr_q);
        grant1 = reset_n & req1_valid & (~req0_valid |  rr_ptr_q);
    end

    // Slot-position decode: wrap points and scan/blank phase of the current slot.
    always_comb begin
        slot_wrap  = (slot_cnt_q == SLOT_LAST);
        frame_swap = slot_wrap && (idx_q == 2'd3);
        phase      = (slot_cnt_q < BLANK_START) ? PH_SCAN : PH_BLANK;
    end

    // Next-state for buffers, arbiter pointer, counters and registered outputs.
    always_comb begin
        shadow_d      = shadow_q;
        last_writer_d = last_writer_q;
        rr_ptr_d      = rr_ptr_q;
        if (grant0) begin
            shadow_d      = req0_data;
            last_writer_d = 1'b0;
            rr_ptr_d      = 1'b1;
        end else if (grant1) begin
            shadow_d      = req1_data;
            last_writer_d = 1'b1;
            rr_ptr_d      = 1'b0;
        end

        // Copy takes the pre-edge shadow, so a write landing on the swap edge waits a frame.
        active_d = frame_swap ? shadow_q : active_q;

        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + CW'(1);
        idx_d      = slot_wrap ? idx_q + 2'd1 : idx_q;
        pwm_cnt_d  = pwm_cnt_q + 4'd1;

        if ((phase == PH_BLANK) || (pwm_cnt_q > brightness)) begin
            an_d = '1;
        end else begin
            an_d = ~(4'b0001 << idx_q);
        end

        unique case (idx_q)
            2'd0:    digit_code_d = active_q[3:0];
            2'd1:    digit_code_d = active_q[7:4];
            2'd2:    digit_code_d = active_q[11:8];
            default: digit_code_d = active_q[15:12];
        endcase

        frame_start_d = frame_swap;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q      <= DASH_FRAME;
            active_q      <= DASH_FRAME;
            idx_q         <= '0;
            slot_cnt_q    <= '0;
            pwm_cnt_q     <= '0;
            rr_ptr_q      <= 1'b0;
            an_q          <= '1;
            digit_code_q  <= DASH_CODE;
            frame_start_q <= 1'b0;
            last_writer_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            idx_q         <= idx_d;
            slot_cnt_q    <= slot_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            an_q          <= an_d;
            digit_code_q  <= digit_code_d;
            frame_start_q <= frame_start_d;
            last_writer_q <= last_writer_d;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign an          = an_q;
    assign digit_code  = digit_code_q;
    assign frame_start = frame_start_q;
    assign last_writer = last_writer_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: a cycle model pushes expected
// registered outputs to a scoreboard queue on each clock edge, and each
// scenario task pops and compares them alongside its own scenario checks.
module tb_seg_display_ctrl;

    localparam int SD = 20;
    localparam int BL = 4;

    logic        clock      = 1'b0;
    logic        reset_n    = 1'b0;
    logic        req0_valid = 1'b0;
    logic [15:0] req0_data  = 16'h0000;
    logic        req1_valid = 1'b0;
    logic [15:0] req1_data  = 16'h0000;
    logic [3:0]  brightness = 4'hF;
    logic        req0_ready;
    logic        req1_ready;
    logic [3:0]  digit_code;
    logic [3:0]  an;
    logic        frame_start;
    logic        last_writer;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected {an, digit_code, frame_start, last_writer} after each clock edge.
    logic [9:0] sb[$];

    // Reference model state.
    logic [15:0] m_shadow = 16'hAAAA;
    logic [15:0] m_active = 16'hAAAA;
    logic [1:0]  m_idx    = 2'd0;
    int          m_slot   = 0;
    logic [3:0]  m_pwm    = 4'd0;
    logic        m_rr     = 1'b0;
    logic        m_lw     = 1'b0;

    always #5 clock = ~clock;

    seg_display_ctrl #(
        .SCAN_DIV(SD),
        .BLANK   (BL)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .brightness (brightness),
        .digit_code (digit_code),
        .an         (an),
        .frame_start(frame_start),
        .last_writer(last_writer)
    );

    // Expected {req0_ready, req1_ready}.
    function automatic logic [1:0] exp_grant(input logic rst_n, input logic v0,
                                             input logic v1, input logic rr);
        logic g0, g1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (rst_n) begin
            if (v0 && v1) begin
                g0 = (rr == 1'b0);
                g1 = (rr == 1'b1);
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        return {g0, g1};
    endfunction

    // Cycle model.
    initial begin
        logic [1:0] g;
        logic [3:0] n_an;
        logic [3:0] n_dc;
        logic       n_fs;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_shadow = 16'hAAAA;
                m_active = 16'hAAAA;
                m_idx    = 2'd0;
                m_slot   = 0;
                m_pwm    = 4'd0;
                m_rr     = 1'b0;
                m_lw     = 1'b0;
                sb.delete();
            end else begin
                g    = exp_grant(1'b1, req0_valid, req1_valid, m_rr);
                n_an = ((m_slot >= SD - BL) || (m_pwm > brightness)) ? 4'hF : ~(4'b0001 << m_idx);
                n_dc = m_active[{m_idx, 2'b00} +: 4];
                n_fs = (m_slot == SD - 1) && (m_idx == 2'd3);
                if (n_fs) m_active = m_shadow;
                if (g[1]) begin
                    m_shadow = req0_data;
                    m_lw     = 1'b0;
                    m_rr     = 1'b1;
                end else if (g[0]) begin
                    m_shadow = req1_data;
                    m_lw     = 1'b1;
                    m_rr     = 1'b0;
                end
                m_slot = m_slot + 1;
                if (m_slot == SD) begin
                    m_slot = 0;
                    m_idx  = m_idx + 2'd1;
                end
                m_pwm = m_pwm + 4'd1;
                sb.push_back({n_an, n_dc, n_fs, m_lw});
            end
        end
    end

    task automatic test_reset();
        logic [11:0] obs;
        reset_n    = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 16'h1234;
        req1_data  = 16'h5678;
        repeat (3) @(posedge clock);
        @(negedge clock);
        obs = {an, digit_code, frame_start, last_writer, req0_ready, req1_ready};
        tests_run++;
        if (obs !== {4'hF, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: observed %h required %h", obs, {4'hF, 4'hA, 4'h0});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_scan();
        logic [11:0] obs, exp;
        int on_cnt = 0, d0_cnt = 0, d3_cnt = 0, fs_cnt = 0, fs_first = 0, fs_last = 0;
        brightness = 4'hF;
        @(posedge clock);
        #1 reset_n = 1'b1;
        sb.delete();
        for (int c = 1; c <= 160; c++) begin
            @(posedge clock);
            #1;
            @(negedge clock);
            tests_run++;
            obs = {an, digit_code, frame_start, last_writer, req0_ready, req1_ready};
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_scan c%0d: observed %h, no expected entry", c, obs);
            end else begin
                exp = {sb.pop_front(), exp_grant(reset_n, req0_valid, req1_valid, m_rr)};
                if (obs !== exp) begin
                    tests_failed++;
                    $display("FAIL sb_scan c%0d: observed %h required %h", c, obs, exp);
                end
            end
            tests_run++;
            if (digit_code !== 4'hA) begin
                tests_failed++;
                $display("FAIL scan_dash c%0d: digit_code %h required a", c, digit_code);
            end
            if (an !== 4'hF) on_cnt++;
            if (an === 4'b1110) d0_cnt++;
            if (an === 4'b0111) d3_cnt++;
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_first == 0) fs_first = c;
                fs_last = c;
            end
        end
        tests_run++;
        if ({on_cnt, d0_cnt, d3_cnt} !== {32'd128, 32'd32, 32'd32}) begin
            tests_failed++;
            $display("FAIL scan_duty: on/d0/d3 %0d/%0d/%0d required 128/32/32", on_cnt, d0_cnt, d3_cnt);
        end
        tests_run++;
        if ({fs_cnt, fs_first, fs_last} !== {32'd2, 32'd80, 32'd160}) begin
            tests_failed++;
            $display("FAIL scan_frame_start: count %0d at %0d..%0d required 2 at 80..160", fs_cnt, fs_first, fs_last);
        end
    endtask

    task automatic test_write();
        logic [11:0] obs, exp;
        logic [3:0]  en;
        bit hs = 0, fs_seen = 0;
        int rdy_cnt = 0;
        sb.delete();
        for (int c = 1; c <= 200; c++) begin
            @(posedge clock);
            #1;
            if (hs) begin
                req0_valid = 1'b0;
                hs = 0;
            end
            if (c == 30) begin
                req0_valid = 1'b1;
                req0_data  = 16'h4321;
            end
            @(negedge clock);
            tests_run++;
            obs = {an, digit_code, frame_start, last_writer, req0_ready, req1_ready};
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_write c%0d: observed %h, no expected entry", c, obs);
            end else begin
                exp = {sb.pop_front(), exp_grant(reset_n, req0_valid, req1_valid, m_rr)};
                if (obs !== exp) begin
                    tests_failed++;
                    $display("FAIL sb_write c%0d: observed %h required %h", c, obs, exp);
                end
            end
            if (req0_ready === 1'b1) begin
                rdy_cnt++;
                hs = 1;
            end
            if (!fs_seen) begin
                tests_run++;
                if (digit_code !== 4'hA) begin
                    tests_failed++;
                    $display("FAIL write_hidden c%0d: digit_code %h required a", c, digit_code);
                end
            end else if (an !== 4'hF) begin
                case (an)
                    4'b1110: en = 4'h1;
                    4'b1101: en = 4'h2;
                    4'b1011: en = 4'h3;
                    4'b0111: en = 4'h4;
                    default: en = 4'hF;
                endcase
                tests_run++;
                if (digit_code !== en) begin
                    tests_failed++;
                    $display("FAIL write_shown c%0d: an %b digit_code %h required %h", c, an, digit_code, en);
                end
            end
            if (frame_start === 1'b1) fs_seen = 1;
        end
        tests_run++;
        if ({rdy_cnt, 31'd0, fs_seen} !== {32'd1, 32'd1}) begin
            tests_failed++;
            $display("FAIL write_handshake: ready cycles %0d swap seen %0d required 1 and 1", rdy_cnt, fs_seen);
        end
    endtask

    task automatic test_brightness();
        logic [11:0] obs, exp;
        int on3 = 0, on0 = 0, on15 = 0;
        sb.delete();
        brightness = 4'd3;
        for (int c = 1; c <= 72; c++) begin
            @(posedge clock);
            #1;
            if (c == 25) brightness = 4'd0;
            if (c == 49) brightness = 4'd15;
            @(negedge clock);
            tests_run++;
            obs = {an, digit_code, frame_start, last_writer, req0_ready, req1_ready};
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_bright c%0d: observed %h, no expected entry", c, obs);
            end else begin
                exp = {sb.pop_front(), exp_grant(reset_n, req0_valid, req1_valid, m_rr)};
                if (obs !== exp) begin
                    tests_failed++;
                    $display("FAIL sb_bright c%0d: observed %h required %h", c, obs, exp);
                end
            end
            if (an !== 4'hF) begin
                if (c <= 25) on3++;
                else if (c <= 49) on0++;
                else on15++;
            end
        end
        tests_run++;
        if (on3 > 8 || on0 > 2 || on15 < 15) begin
            tests_failed++;
            $display("FAIL bright_duty: on counts %0d/%0d/%0d required <=8, <=2, >=15", on3, on0, on15);
        end
    endtask

    task automatic test_swap_edge();
        logic [11:0] obs, exp;
        logic [15:0] expf = 16'h0000;
        logic [1:0]  k;
        bit hs = 0, expf_ok = 0, kv;
        int stage = 0, fs_after = 0, grant_c = 0, end_c = 0;
        sb.delete();
        for (int c = 1; c <= 400; c++) begin
            @(posedge clock);
            #1;
            if (hs) begin
                req0_valid = 1'b0;
                hs = 0;
            end
            if (c == 2) begin
                req0_valid = 1'b1;
                req0_data  = 16'h5678;
            end else if (stage == 1 && !req0_valid && m_slot == SD - 1 && m_idx == 2'd3) begin
                req0_valid = 1'b1;
                req0_data  = 16'h9ABC;
                stage = 2;
            end
            @(negedge clock);
            tests_run++;
            obs = {an, digit_code, frame_start, last_writer, req0_ready, req1_ready};
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_swap c%0d: observed %h, no expected entry", c, obs);
            end else begin
                exp = {sb.pop_front(), exp_grant(reset_n, req0_valid, req1_valid, m_rr)};
                if (obs !== exp) begin
                    tests_failed++;
                    $display("FAIL sb_swap c%0d: observed %h required %h", c, obs, exp);
                end
            end
            if (expf_ok && an !== 4'hF) begin
                kv = 1;
                case (an)
                    4'b1110: k = 2'd0;
                    4'b1101: k = 2'd1;
                    4'b1011: k = 2'd2;
                    4'b0111: k = 2'd3;
                    default: begin k = 2'd0; kv = 0; end
                endcase
                tests_run++;
                if (!kv || digit_code !== expf[{k, 2'b00} +: 4]) begin
                    tests_failed++;
                    $display("FAIL swap_frame c%0d: an %b digit_code %h frame %h", c, an, digit_code, expf);
                end
            end
            if (req0_ready === 1'b1) begin
                hs = 1;
                if (stage == 0) stage = 1;
                else if (stage == 2) begin
                    stage = 3;
                    grant_c = c;
                end
            end
            if (stage == 3 && frame_start === 1'b1) begin
                fs_after++;
                if (fs_after == 1) begin
                    tests_run++;
                    if (c != grant_c + 1) begin
                        tests_failed++;
                        $display("FAIL swap_align: frame_start at c%0d required c%0d", c, grant_c + 1);
                    end
                    expf = 16'h5678;
                    expf_ok = 1;
                end else if (fs_after == 2) begin
                    expf = 16'h9ABC;
                    end_c = c + 25;
                end
            end
            if (end_c != 0 && c >= end_c) break;
        end
        req0_valid = 1'b0;
        tests_run++;
        if (fs_after != 2) begin
            tests_failed++;
            $display("FAIL swap_timeout: frame_starts after grant %0d required 2", fs_after);
        end
    endtask

    task automatic test_reset_midframe();
        logic [11:0] obs, exp;
        bit found = 0, hs = 0;
        sb.delete();
        for (int c = 1; c <= 100; c++) begin
            @(posedge clock);
            #1;
            if (m_idx == 2'd2 && m_slot == 6) begin
                found = 1;
                break;
            end
            @(negedge clock);
            tests_run++;
            obs = {an, digit_code, frame_start, last_writer, req0_ready, req1_ready};
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_rstmid c%0d: observed %h, no expected entry", c, obs);
            end else begin
                exp = {sb.pop_front(), exp_grant(reset_n, req0_valid, req1_valid, m_rr)};
                if (obs !== exp) begin
                    tests_failed++;
                    $display("FAIL sb_rstmid c%0d: observed %h required %h", c, obs, exp);
                end
            end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL rstmid_timeout: digit 2 not reached, idx %0d", m_idx);
        end
        reset_n    = 1'b0;
        req1_valid = 1'b1;
        req1_data  = 16'hBEEF;
        #1;
        tests_run++;
        obs = {an, digit_code, frame_start, last_writer, req0_ready, req1_ready};
        if (obs !== {4'hF, 4'hA, 4'h0}) begin
            tests_failed++;
            $display("FAIL rstmid_immediate: observed %h required %h", obs, {4'hF, 4'hA, 4'h0});
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests_run++;
        if ({an, req1_ready} !== {4'hF, 1'b0}) begin
            tests_failed++;
            $display("FAIL rstmid_hold: an %b req1_ready %b required 1111 and 0", an, req1_ready);
        end
        @(posedge clock);
        #1 reset_n = 1'b1;
        sb.delete();
        #1;
        tests_run++;
        if (req1_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_regrant: req1_ready %b required 1", req1_ready);
        end
        hs = (req1_ready === 1'b1);
        for (int c = 1; c <= 30; c++) begin
            @(posedge clock);
            #1;
            if (hs) begin
                req1_valid = 1'b0;
                hs = 0;
            end
            @(negedge clock);
            tests_run++;
            obs = {an, digit_code, frame_start, last_writer, req0_ready, req1_ready};
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_rstmid2 c%0d: observed %h, no expected entry", c, obs);
            end else begin
                exp = {sb.pop_front(), exp_grant(reset_n, req0_valid, req1_valid, m_rr)};
                if (obs !== exp) begin
                    tests_failed++;
                    $display("FAIL sb_rstmid2 c%0d: observed %h required %h", c, obs, exp);
                end
            end
            if (c == 1) begin
                tests_run++;
                if ({an, last_writer} !== {4'b1110, 1'b1}) begin
                    tests_failed++;
                    $display("FAIL rstmid_restart: an %b last_writer %b required 1110 and 1", an, last_writer);
                end
            end
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_arb();
        logic [11:0] obs, exp;
        logic [1:0]  want;
        logic        prev_id = 1'b0;
        logic        id;
        sb.delete();
        req0_data = 16'h1111;
        req1_data = 16'h2222;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clock);
            #1;
            if (c == 1) begin
                req0_valid = 1'b1;
                req1_valid = 1'b1;
            end
            @(negedge clock);
            tests_run++;
            obs = {an, digit_code, frame_start, last_writer, req0_ready, req1_ready};
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_arb c%0d: observed %h, no expected entry", c, obs);
            end else begin
                exp = {sb.pop_front(), exp_grant(reset_n, req0_valid, req1_valid, m_rr)};
                if (obs !== exp) begin
                    tests_failed++;
                    $display("FAIL sb_arb c%0d: observed %h required %h", c, obs, exp);
                end
            end
            id   = ((c % 2) == 0);
            want = id ? 2'b01 : 2'b10;
            tests_run++;
            if ({req0_ready, req1_ready} !== want) begin
                tests_failed++;
                $display("FAIL arb_alternate c%0d: ready %b required %b", c, {req0_ready, req1_ready}, want);
            end
            if (c > 1) begin
                tests_run++;
                if (last_writer !== prev_id) begin
                    tests_failed++;
                    $display("FAIL arb_last_writer c%0d: %b required %b", c, last_writer, prev_id);
                end
            end
            prev_id = id;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_write();
        test_brightness();
        test_swap_edge();
        test_reset_midframe();
        test_arb();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
Scan controller and write arbiter for the 4-digit multiplexed seven-segment display. It holds a double-buffered 4-nibble frame and arbitrates frame writes from two requesters, for example the PWM duty readout and a status source. It sequences the digit scan with a blanking gap between digits to suppress ghosting, and applies 16-level brightness gating. It drives the nibble-to-segment decoder through digit_code and drives the anode enables directly.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot, including blanking; must be at least BLANK+1.
BLANK, 500, cycles at the end of each slot with all anodes off; must be at least 1.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has a frame to write
req0_data  in  16  requester 0 frame; bits [3:0] are digit 0 (an[0]), bits [15:12] are digit 3
req0_ready  out  1  requester 0 write accepted this cycle
req1_valid  in  1  requester 1 has a frame to write
req1_data  in  16  requester 1 frame; same layout as req0_data
req1_ready  out  1  requester 1 write accepted this cycle
brightness  in  4  on-duty within each scan window: (brightness+1)/16
digit_code  out  4  nibble for the active digit, sent to the decoder
an  out  4  anode enables, active-low
frame_start  out  1  one-cycle pulse when the scan returns to digit 0
last_writer  out  1  id of the most recently accepted requester

Behaviour:
- Reset (async, reset_n=0):
  - shadow and active buffers = 16'hAAAA (code 10 = dash on every digit)
  - idx=0, slot_cnt=0, pwm_cnt=0, rr_ptr=0
  - an=4'b1111, digit_code=4'hA, frame_start=0, last_writer=0
  - req*_ready=0 while reset is asserted
- Arbitration (combinational grant, one write per cycle):
  - Only one requester valid: it is granted.
  - Both valid: the requester selected by rr_ptr wins.
  - On any grant, rr_ptr is set to the id of the loser (the requester not granted).
  - reqN_ready=1 exactly in the cycle the grant transfers; reqN_data is written to shadow on that edge and last_writer updates on the same edge.
  - Valid is held until ready; ready never asserts without valid.
- Counters:
  - slot_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, idx increments modulo 4.
  - pwm_cnt is a free-running 4-bit counter.
- Phases: SCAN when slot_cnt < SCAN_DIV-BLANK; BLANK otherwise.
- Outputs are registered and reflect the previous cycle's counter state (1-cycle latency):
  - an = 4'b1111 in BLANK, or when pwm_cnt > brightness.
  - Otherwise an = the idx-th bit low (idx 0 gives 1110, idx 3 gives 0111).
  - digit_code = active[4*idx+3 : 4*idx], valid in both phases.
- Frame swap:
  - When slot_cnt wraps and idx goes 3→0, shadow is copied to active and frame_start pulses on the following cycle.
  - A write accepted on the swap edge is not in that copy; it becomes visible at the next swap.
- brightness=15 keeps the digit on for the whole SCAN phase; brightness=0 gives 1/16 duty. brightness is sampled every cycle with no latching.
- Reset asserted mid-frame: returns immediately to reset values; any in-flight request is dropped and must be re-presented.

Test Plan:
- SCAN_DIV=20, BLANK=4, brightness=15, no requests, release reset: an cycles 1110, 0111-style one-hot-low per digit, with 16 cycles on and 4 cycles of 1111 per slot; digit_code stays 4'hA throughout; frame_start pulses every 80 cycles.
- Write 16'h4321 from req0 mid-frame: req0_ready is high for 1 cycle; digits still show A until the next frame_start, then digit_code reads 1,2,3,4 for an=1110,1101,1011,0111.
- Both requesters valid continuously, req0=16'h1111, req1=16'h2222: grants alternate 0,1,0,1 starting with req0; last_writer tracks each grant.
- brightness=3: within each 16-cycle SCAN window, an is active when pwm_cnt is 0–3, i.e. 4 of every 16 cycles; brightness changes take effect on the next cycle.
- Write accepted on the idx 3→0 swap edge: the old value is displayed for the whole new frame, and the new value appears at the following frame_start.
- Pull reset_n low during digit 2 with req1_valid held: an=1111 and digit_code=A immediately; after release, the scan restarts at digit 0 and req1 is granted on the first cycle.
